// File: rtl/sensor_sequencer_if.sv
// Control-side handshake between the register block and the capture sequencer.
// With CONT_CAPTURE_EN defined the bundle also carries the 'continuous' request.
interface sensor_sequencer_if #(
  parameter int EXP_W = 16
);
  logic             start;
  logic             abort;
  logic [EXP_W-1:0] exp_time;
  logic             busy;
  logic             frame_done;
`ifdef CONT_CAPTURE_EN
  logic             continuous;

  modport master (output start, abort, exp_time, continuous, input busy, frame_done);
  modport slave  (input start, abort, exp_time, continuous, output busy, frame_done);
`else
  modport master (output start, abort, exp_time, input busy, frame_done);
  modport slave  (input start, abort, exp_time, output busy, frame_done);
`endif
endinterface

// File: rtl/sensor_sequencer.sv
// Pixel-array capture sequencer: erase -> expose -> convert -> read, then back to idle.
// Optional back-to-back capture is enabled by defining CONT_CAPTURE_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start; all strobes low
// S_ERASE   | pixel erase, C_ERASE cycles
// S_EXPOSE  | integration, latched exposure cycles (0 treated as 1)
// S_CONVERT | ADC conversion, C_CONVERT cycles
// S_READ    | C_READ cycles per pixel, pixel_select walks 0..PIXEL_COUNT-1
module sensor_sequencer #(
  parameter int PIXEL_COUNT = 4,
  parameter int C_ERASE     = 5,
  parameter int C_CONVERT   = 255,
  parameter int C_READ      = 2,
  parameter int EXP_W       = 16,
  parameter int PSEL_W      = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  sensor_sequencer_if.slave ctrl,
  output logic              erase,
  output logic              expose,
  output logic              convert,
  output logic              read,
  output logic [PSEL_W-1:0] pixel_select
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = max_i(max_i(EXP_W, $clog2(C_CONVERT + 1)),
                               max_i($clog2(C_ERASE + 1), $clog2(C_READ + 1)));

  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ERASE_LAST   = CNT_W'(C_ERASE - 1);
  localparam logic [CNT_W-1:0]  CONVERT_LAST = CNT_W'(C_CONVERT - 1);
  localparam logic [CNT_W-1:0]  READ_LAST    = CNT_W'(C_READ - 1);
  localparam logic [PSEL_W-1:0] PSEL_ONE     = PSEL_W'(1);
  localparam logic [PSEL_W-1:0] PSEL_LAST    = PSEL_W'(PIXEL_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [EXP_W-1:0] exp_lat;
  logic [EXP_W-1:0] exp_next;
  logic [CNT_W-1:0] expose_last;
  logic             busy_q;
  logic             frame_done_q;

  // exp_lat is never 0 once latched, so the subtraction cannot underflow in EXPOSE
  assign exp_next    = (ctrl.exp_time == '0) ? EXP_W'(1) : ctrl.exp_time;
  assign expose_last = CNT_W'(exp_lat) - CNT_ONE;

  assign ctrl.busy       = busy_q;
  assign ctrl.frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      exp_lat      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      erase        <= 1'b0;
      expose       <= 1'b0;
      convert      <= 1'b0;
      read         <= 1'b0;
      pixel_select <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (state != S_IDLE && ctrl.abort) begin
        state        <= S_IDLE;
        cnt          <= '0;
        busy_q       <= 1'b0;
        erase        <= 1'b0;
        expose       <= 1'b0;
        convert      <= 1'b0;
        read         <= 1'b0;
        pixel_select <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (ctrl.start) begin
              state   <= S_ERASE;
              cnt     <= '0;
              exp_lat <= exp_next;
              busy_q  <= 1'b1;
              erase   <= 1'b1;
            end
          end
          S_ERASE: begin
            if (cnt == ERASE_LAST) begin
              state  <= S_EXPOSE;
              cnt    <= '0;
              erase  <= 1'b0;
              expose <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_EXPOSE: begin
            if (cnt == expose_last) begin
              state   <= S_CONVERT;
              cnt     <= '0;
              expose  <= 1'b0;
              convert <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_CONVERT: begin
            if (cnt == CONVERT_LAST) begin
              state        <= S_READ;
              cnt          <= '0;
              convert      <= 1'b0;
              read         <= 1'b1;
              pixel_select <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          S_READ: begin
            if (cnt == READ_LAST) begin
              cnt <= '0;
              if (pixel_select == PSEL_LAST) begin
                frame_done_q <= 1'b1;
                read         <= 1'b0;
                pixel_select <= '0;
`ifdef CONT_CAPTURE_EN
                if (ctrl.continuous) begin
                  state   <= S_ERASE;
                  exp_lat <= exp_next;
                  erase   <= 1'b1;
                end else begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
                end
`else
                state  <= S_IDLE;
                busy_q <= 1'b0;
`endif
              end else begin
                pixel_select <= pixel_select + PSEL_ONE;
              end
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_sequencer.sv
// Scoreboard bench for sensor_sequencer: directed captures push expected frame
// summaries, a negedge monitor measures each frame and pops/compares on frame_done.
module tb_sensor_sequencer;

  localparam int EXP_W = 16;

  typedef struct {
    int          erase_n;
    int          expose_n;
    int          convert_n;
    int          read_n;
    int          busy_n;
    logic [15:0] psel_seq;
    logic        erase_at_done;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       erase, expose, convert, read;
  logic [1:0] pixel_select;

  int checks = 0;
  int failures = 0;

  frame_t exp_q[$];

  int          m_erase, m_expose, m_convert, m_read, m_busy;
  logic [15:0] m_psel;

  sensor_sequencer_if #(.EXP_W(EXP_W)) bus ();

  sensor_sequencer #(
    .PIXEL_COUNT(4),
    .C_ERASE    (5),
    .C_CONVERT  (255),
    .C_READ     (2),
    .EXP_W      (EXP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (bus),
    .erase       (erase),
    .expose      (expose),
    .convert     (convert),
    .read        (read),
    .pixel_select(pixel_select)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Read sequence 0,0,1,1,2,2,3,3 packed two bits per read cycle
  function automatic frame_t mk_frame(input int exp_cycles, input logic ead);
    frame_t f;
    f.erase_n       = 5;
    f.expose_n      = exp_cycles;
    f.convert_n     = 255;
    f.read_n        = 8;
    f.busy_n        = 5 + exp_cycles + 255 + 8;
    f.psel_seq      = 16'h05AF;
    f.erase_at_done = ead;
    return f;
  endfunction

  task automatic clear_meas();
    m_erase = 0; m_expose = 0; m_convert = 0; m_read = 0; m_busy = 0; m_psel = '0;
  endtask

  always @(negedge clk) begin
    frame_t e;
    if (reset) begin
      clear_meas();
    end else begin
      checks++;
      if ((bus.busy ? !$onehot({erase, expose, convert, read})
                    : ({erase, expose, convert, read} != 4'b0)) ||
          (!read && pixel_select != 2'd0)) begin
        failures++;
        $display("FAIL strobes: got busy=%0b e/x/c/r=%b psel=%0d required one-hot when busy, psel 0 outside read",
                 bus.busy, {erase, expose, convert, read}, pixel_select);
      end
      if (bus.frame_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_done: got unexpected pulse, required none");
        end else begin
          e = exp_q.pop_front();
          cmp("erase_len",     m_erase,   e.erase_n);
          cmp("expose_len",    m_expose,  e.expose_n);
          cmp("convert_len",   m_convert, e.convert_n);
          cmp("read_len",      m_read,    e.read_n);
          cmp("busy_len",      m_busy,    e.busy_n);
          cmp("psel_seq",      m_psel,    e.psel_seq);
          cmp("erase_at_done", erase,     e.erase_at_done);
        end
        clear_meas();
      end
      if (!bus.busy) begin
        clear_meas();
      end else begin
        m_busy++;
        if (erase)   m_erase++;
        if (expose)  m_expose++;
        if (convert) m_convert++;
        if (read) begin
          m_read++;
          m_psel = {m_psel[13:0], pixel_select};
        end
      end
    end
  end

  task automatic start_pulse(input logic [EXP_W-1:0] e);
    bus.start    = 1'b1;
    bus.exp_time = e;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.frame_done && n < limit);
    if (!bus.frame_done) begin
      checks++;
      failures++;
      $display("FAIL wait_done: got no frame_done within %0d cycles, required pulse", limit);
    end
  endtask

  // which: 0 expose, 1 convert, 2 read at pixel 2
  task automatic wait_phase(input int which, input int limit);
    int   n = 0;
    logic hit;
    do begin
      @(posedge clk); #1;
      n++;
      case (which)
        0:       hit = expose;
        1:       hit = convert;
        default: hit = read && pixel_select == 2'd2;
      endcase
    end while (!hit && n < limit);
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_phase%0d: got no phase within %0d cycles, required phase", which, limit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.exp_time = '0;
`ifdef CONT_CAPTURE_EN
    bus.continuous = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_outputs", {bus.busy, bus.frame_done, erase, expose, convert, read, pixel_select}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    exp_q.push_back(mk_frame(10, 1'b0));
    start_pulse(16'd10);
    cmp("busy_after_start", {bus.busy, erase}, 2'b11);
    wait_done(400);

    exp_q.push_back(mk_frame(1, 1'b0));
    start_pulse(16'd0);
    wait_done(400);

    exp_q.push_back(mk_frame(7, 1'b0));
    start_pulse(16'd7);
    wait_phase(0, 50);
    bus.exp_time = 16'd50;
    wait_done(400);

    start_pulse(16'd10);
    wait_phase(1, 50);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    cmp("abort_idle", {bus.busy, bus.frame_done, erase, expose, convert, read, pixel_select}, 0);
    @(posedge clk); #1;
    cmp("abort_no_done", {bus.busy, bus.frame_done}, 0);
    exp_q.push_back(mk_frame(12, 1'b0));
    start_pulse(16'd12);
    wait_done(400);

    exp_q.push_back(mk_frame(10, 1'b0));
    exp_q.push_back(mk_frame(10, 1'b0));
    bus.start    = 1'b1;
    bus.exp_time = 16'd10;
    wait_done(400);
    @(posedge clk); #1;
    cmp("held_start_restart", {bus.busy, erase, bus.frame_done}, 3'b110);
    bus.start = 1'b0;
    wait_done(400);

    start_pulse(16'd3);
    wait_phase(2, 400);
    reset = 1'b1;
    @(posedge clk); #1;
    cmp("reset_in_read", {bus.busy, bus.frame_done, erase, expose, convert, read, pixel_select}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef CONT_CAPTURE_EN
    bus.continuous = 1'b1;
    exp_q.push_back(mk_frame(10, 1'b1));
    exp_q.push_back(mk_frame(20, 1'b0));
    start_pulse(16'd10);
    bus.exp_time = 16'd20;
    wait_done(400);
    cmp("cont_busy_held", {bus.busy, erase}, 2'b11);
    bus.continuous = 1'b0;
    wait_done(400);
`endif

    repeat (5) @(posedge clk);
    #1;
    cmp("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
